ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of the PC+4 field.
REQ-002 Parameter DATA_WIDTH, default 32, width of the ALU-result and store-data fields.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, synchronous and active-low.
REQ-005 valid_i  in  1  execute stage presents a valid instruction.
REQ-006 ready_o  out  1  this stage can accept a beat this cycle.
REQ-007 flush_i  in  1  hazard unit kills every instruction held in this stage.
REQ-008 alu_resultE_i, write_dataE_i  in  DATA_WIDTH each  ALU result; store data.
REQ-009 rdE_i  in  5  destination register; pc_plus4E_i  in  ADDRESS_WIDTH  PC+4.
REQ-010 reg_writeE_i  in  1; result_srcE_i  in  2; mem_writeE_i  in  1  execute-stage control.
REQ-011 valid_o  out  1  memory stage receives a valid instruction.
REQ-012 ready_i  in  1  memory stage accepts the beat this cycle.
REQ-013 alu_resultM_o, write_dataM_o, rdM_o, pc_plus4M_o, reg_writeM_o, result_srcM_o, mem_writeM_o  out  widths as the matching E inputs  memory-stage copies.

Function
REQ-014 Accept: valid_i && ready_o at a rising edge; Deliver: valid_o && ready_i at a rising edge.
REQ-015 Latency: an accepted beat appears on the M outputs, with valid_o=1, in the cycle after acceptance when the main register was empty or delivered in the same edge.
REQ-016 Internal storage: main register (drives outputs) plus one skid register; states EMPTY (none valid), FULL (main only), SKID (main and skid).
REQ-017 EMPTY: accept -> FULL; otherwise stay.
REQ-018 FULL: accept and deliver -> FULL with new beat in main; deliver only -> EMPTY; accept only -> SKID, beat in skid; neither -> stay.
REQ-019 SKID: deliver -> FULL, skid contents move to main; otherwise stay; no accept is possible in SKID.
REQ-020 ready_o is a registered signal, 1 in EMPTY and FULL and 0 in SKID; it never depends combinationally on ready_i.
REQ-021 Order is preserved: beats leave in acceptance order, with no duplication or loss.
REQ-022 reg_writeM_o and mem_writeM_o equal the stored bits ANDed with valid_o; a bubble never writes.
REQ-023 Data fields hold their values whenever the main register is not loaded; the hold includes a stall (valid_o=1, ready_i=0).
REQ-024 flush_i=1 at an edge -> state EMPTY and both valid bits cleared; flush overrides a simultaneous accept and deliver, and the beat offered that cycle is dropped.
REQ-025 Data fields need not clear on flush; outputs observed while valid_o=0 carry no meaning except REQ-022.

Reset
REQ-026 rst_ni=0 at an edge -> state EMPTY, valid_o=0, ready_o=1, all M data and control outputs 0.
REQ-027 Reset takes priority over flush_i, valid_i and ready_i; reset mid-SKID discards both held beats.
REQ-028 Outputs are defined from the first edge with rst_ni=0; there is no asynchronous path.

Configuration
REQ-029 Macro EX_MEM_SKID_EN defined: skid register and SKID state compiled in, behaviour per REQ-016..REQ-020.
REQ-030 Macro EX_MEM_SKID_EN undefined: no skid register and no SKID state.
REQ-031 Without the macro, ready_o = ready_i || !valid_o, combinationally.
REQ-032 Without the macro, accept loads main; delivery without accept -> EMPTY.
REQ-033 All other requirements hold in both builds.

Verification
REQ-034 Reset with valid_i=1 -> valid_o=0, ready_o=1, alu_resultM_o=0, reg_writeM_o=0.
REQ-035 Streaming, ready_i=1: beats alu_result 0x10, 0x20, 0x30 on consecutive cycles -> the same values on alu_resultM_o one cycle later, back-to-back.
REQ-036 Stall (skid build): accept A=0x11, then ready_i=0 while B=0x22 is offered -> B accepted into skid, ready_o=0 next cycle, A held on outputs.
REQ-037 Stall release: ready_i=1 -> outputs A then B on consecutive cycles, and ready_o returns to 1.
REQ-038 Flush in SKID with mem_writeE_i=1 offered -> valid_o=0 and mem_writeM_o=0 next cycle; no beat is emitted afterwards.
REQ-039 Without EX_MEM_SKID_EN: valid_o=1, ready_i=0 -> ready_o=0 in the same cycle; set ready_i=1 with valid_i=1 -> next beat loads at that edge.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_if
// Purpose  : Bundles the EX->MEM pipeline handshake, flush and payload signals
//            so they can be passed as a single port.
// Ports    : none (signal bundle only)
//            slave  modport - view of the pipeline register itself
//                             (E-side and control inputs, M-side outputs)
//            master modport - view of the surrounding pipeline
//                             (drives E side, flush, downstream ready)
// Revision : 1.0 - initial release
// ============================================================================
interface ex_mem_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // Upstream (execute) side
    logic                     valid_i;
    logic                     ready_o;
    logic                     flush_i;
    logic [DATA_WIDTH-1:0]    alu_resultE_i;
    logic [DATA_WIDTH-1:0]    write_dataE_i;
    logic [4:0]               rdE_i;
    logic [ADDRESS_WIDTH-1:0] pc_plus4E_i;
    logic                     reg_writeE_i;
    logic [1:0]               result_srcE_i;
    logic                     mem_writeE_i;

    // Downstream (memory) side
    logic                     valid_o;
    logic                     ready_i;
    logic [DATA_WIDTH-1:0]    alu_resultM_o;
    logic [DATA_WIDTH-1:0]    write_dataM_o;
    logic [4:0]               rdM_o;
    logic [ADDRESS_WIDTH-1:0] pc_plus4M_o;
    logic                     reg_writeM_o;
    logic [1:0]               result_srcM_o;
    logic                     mem_writeM_o;

    modport slave (
        input  valid_i, flush_i, alu_resultE_i, write_dataE_i, rdE_i,
               pc_plus4E_i, reg_writeE_i, result_srcE_i, mem_writeE_i, ready_i,
        output ready_o, valid_o, alu_resultM_o, write_dataM_o, rdM_o,
               pc_plus4M_o, reg_writeM_o, result_srcM_o, mem_writeM_o
    );

    modport master (
        output valid_i, flush_i, alu_resultE_i, write_dataE_i, rdE_i,
               pc_plus4E_i, reg_writeE_i, result_srcE_i, mem_writeE_i, ready_i,
        input  ready_o, valid_o, alu_resultM_o, write_dataM_o, rdM_o,
               pc_plus4M_o, reg_writeM_o, result_srcM_o, mem_writeM_o
    );
endinterface : ex_mem_stage_if
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX->MEM pipeline register with valid/ready handshake and flush.
//            Build option EX_MEM_SKID_EN:
//              defined   - main + skid register, registered ready_o
//                          (EMPTY / FULL / SKID)
//              undefined - main register only, ready_o = ready_i || !valid_o
// Ports    : clk_i   - clock, all state changes on the rising edge
//            rst_ni  - synchronous active-low reset
//            bus     - ex_mem_stage_if.slave: E-side payload, valid_i,
//                      ready_o, flush_i; M-side payload, valid_o, ready_i
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ex_mem_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    write_data;
        logic [4:0]               rd;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
        logic                     reg_write;
        logic [1:0]               result_src;
        logic                     mem_write;
    } payload_t;

    payload_t w_in_beat;
    payload_t r_main;
    logic     w_valid;
    logic     w_ready;
    logic     w_accept;
    logic     w_deliver;

    assign w_in_beat = '{
        alu_result: bus.alu_resultE_i,
        write_data: bus.write_dataE_i,
        rd:         bus.rdE_i,
        pc_plus4:   bus.pc_plus4E_i,
        reg_write:  bus.reg_writeE_i,
        result_src: bus.result_srcE_i,
        mem_write:  bus.mem_writeE_i
    };

`ifdef EX_MEM_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t   r_state;
    state_t   w_state_next;
    payload_t r_skid;
    logic     r_ready;
    logic     w_load_main_in;
    logic     w_load_main_skid;
    logic     w_load_skid;

    // ready_o comes straight from a flop so the upstream path never sees
    // ready_i combinationally; the skid slot absorbs the one beat that can
    // arrive while the downstream stalls.
    assign w_ready = r_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next   = ST_FULL;
                    w_load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_accept && w_deliver) begin
                    w_load_main_in = 1'b1;
                end else if (w_deliver) begin
                    w_state_next = ST_EMPTY;
                end else if (w_accept) begin
                    w_state_next = ST_SKID;
                    w_load_skid  = 1'b1;
                end
            end
            ST_SKID: begin
                // ready_o is low here, so no new beat can be accepted
                if (w_deliver) begin
                    w_state_next     = ST_FULL;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
        // Flush kills everything held plus the beat offered this cycle
        if (bus.flush_i) begin
            w_state_next     = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != ST_SKID);
            if (w_load_main_in) begin
                r_main <= w_in_beat;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_beat;
            end
        end
    end
`else
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_load_main_in;

    // Single-entry register: free when empty or when the held beat leaves
    // at this same edge.
    assign w_ready = bus.ready_i || !w_valid;

    always_comb begin
        w_state_next   = r_state;
        w_load_main_in = 1'b0;
        if (bus.flush_i) begin
            w_state_next = ST_EMPTY;
        end else if (w_accept) begin
            w_state_next   = ST_FULL;
            w_load_main_in = 1'b1;
        end else if (w_deliver) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_main_in) begin
                r_main <= w_in_beat;
            end
        end
    end
`endif

    assign w_valid   = (r_state != ST_EMPTY);
    assign w_accept  = bus.valid_i && w_ready;
    assign w_deliver = w_valid && bus.ready_i;

    assign bus.ready_o       = w_ready;
    assign bus.valid_o       = w_valid;
    assign bus.alu_resultM_o = r_main.alu_result;
    assign bus.write_dataM_o = r_main.write_data;
    assign bus.rdM_o         = r_main.rd;
    assign bus.pc_plus4M_o   = r_main.pc_plus4;
    assign bus.result_srcM_o = r_main.result_src;
    // Write enables are qualified by valid so a bubble can never write
    assign bus.reg_writeM_o  = r_main.reg_write & w_valid;
    assign bus.mem_writeM_o  = r_main.mem_write & w_valid;

endmodule : ex_mem_stage
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Self-checking bench for ex_mem_stage. A queue model of the beats
//            held in the stage is compared against the DUT every cycle, and
//            directed scenarios carry hand-computed literal expectations.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst_n;

    ex_mem_stage_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ex_mem_stage #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: an ordered list of beats currently held by the stage
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] alu;
        logic [DW-1:0] wd;
        logic [4:0]    rd;
        logic [AW-1:0] pc;
        logic          rw;
        logic [1:0]    rs;
        logic          mw;
    } beat_t;

    beat_t q[$];
    bit    live = 1'b0;

    function automatic bit model_ready();
`ifdef EX_MEM_SKID_EN
        return (q.size() < 2);
`else
        return (bus.ready_i || q.size() == 0);
`endif
    endfunction

    always @(posedge clk) begin
        beat_t b;
        bit    acc;
        bit    del;
        if (!rst_n) begin
            q.delete();
            live = 1'b1;
        end else if (live) begin
            acc = bus.valid_i && model_ready();
            del = (q.size() != 0) && bus.ready_i;
            if (bus.flush_i) begin
                q.delete();
            end else begin
                if (del) q.delete(0);
                if (acc) begin
                    b.alu = bus.alu_resultE_i;
                    b.wd  = bus.write_dataE_i;
                    b.rd  = bus.rdE_i;
                    b.pc  = bus.pc_plus4E_i;
                    b.rw  = bus.reg_writeE_i;
                    b.rs  = bus.result_srcE_i;
                    b.mw  = bus.mem_writeE_i;
                    q.push_back(b);
                end
            end
        end
    end

    // Compare process: mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (live) begin
            check("sb_valid_o", 64'(bus.valid_o), 64'(q.size() != 0));
            check("sb_ready_o", 64'(bus.ready_o), 64'(model_ready()));
            if (q.size() != 0) begin
                check("sb_alu_result", 64'(bus.alu_resultM_o), 64'(q[0].alu));
                check("sb_write_data", 64'(bus.write_dataM_o), 64'(q[0].wd));
                check("sb_rd",         64'(bus.rdM_o),         64'(q[0].rd));
                check("sb_pc_plus4",   64'(bus.pc_plus4M_o),   64'(q[0].pc));
                check("sb_result_src", 64'(bus.result_srcM_o), 64'(q[0].rs));
                check("sb_reg_write",  64'(bus.reg_writeM_o),  64'(q[0].rw));
                check("sb_mem_write",  64'(bus.mem_writeM_o),  64'(q[0].mw));
            end else begin
                check("sb_bubble_reg_write", 64'(bus.reg_writeM_o), 64'd0);
                check("sb_bubble_mem_write", 64'(bus.mem_writeM_o), 64'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] alu, input logic rw, input logic mw);
        bus.valid_i       = v;
        bus.alu_resultE_i = alu;
        bus.write_dataE_i = alu ^ 32'hA5A5_0000;
        bus.rdE_i         = alu[4:0];
        bus.pc_plus4E_i   = alu + 32'd4;
        bus.reg_writeE_i  = rw;
        bus.result_srcE_i = alu[1:0];
        bus.mem_writeE_i  = mw;
    endtask

    initial begin
        // Reset with a valid beat offered
        rst_n       = 1'b0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b0;
        offer(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step();
        step();
        check("rst_valid_o",    64'(bus.valid_o),       64'd0);
        check("rst_ready_o",    64'(bus.ready_o),       64'd1);
        check("rst_alu_result", 64'(bus.alu_resultM_o), 64'd0);
        check("rst_reg_write",  64'(bus.reg_writeM_o),  64'd0);
        check("rst_write_data", 64'(bus.write_dataM_o), 64'd0);
        check("rst_pc_plus4",   64'(bus.pc_plus4M_o),   64'd0);
        check("rst_mem_write",  64'(bus.mem_writeM_o),  64'd0);
        rst_n = 1'b1;
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Streaming with ready_i held high
        bus.ready_i = 1'b1;
        offer(1'b1, 32'h10, 1'b1, 1'b0);
        step();
        check("stream_0x10_valid", 64'(bus.valid_o),       64'd1);
        check("stream_0x10",       64'(bus.alu_resultM_o), 64'h10);
        check("stream_0x10_wdata", 64'(bus.write_dataM_o), 64'hA5A5_0010);
        offer(1'b1, 32'h20, 1'b1, 1'b0);
        step();
        check("stream_0x20", 64'(bus.alu_resultM_o), 64'h20);
        offer(1'b1, 32'h30, 1'b0, 1'b1);
        step();
        check("stream_0x30",       64'(bus.alu_resultM_o), 64'h30);
        check("stream_0x30_pc",    64'(bus.pc_plus4M_o),   64'h34);
        check("stream_0x30_mw",    64'(bus.mem_writeM_o),  64'd1);
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("stream_drained", 64'(bus.valid_o), 64'd0);

`ifdef EX_MEM_SKID_EN
        // Stall: A accepted, B arrives while downstream stalls -> skid
        offer(1'b1, 32'h11, 1'b1, 1'b0);
        step();
        check("stall_A_out", 64'(bus.alu_resultM_o), 64'h11);
        offer(1'b1, 32'h22, 1'b1, 1'b0);
        bus.ready_i = 1'b0;
        step();
        check("stall_ready_low", 64'(bus.ready_o),       64'd0);
        check("stall_A_held",    64'(bus.alu_resultM_o), 64'h11);
        check("stall_valid",     64'(bus.valid_o),       64'd1);
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        bus.ready_i = 1'b1;
        step();
        check("release_B_out",   64'(bus.alu_resultM_o), 64'h22);
        check("release_ready",   64'(bus.ready_o),       64'd1);
        step();
        check("release_empty",   64'(bus.valid_o),       64'd0);

        // Flush while in SKID with a store offered
        bus.ready_i = 1'b0;
        offer(1'b1, 32'h33, 1'b1, 1'b1);
        step();
        offer(1'b1, 32'h44, 1'b1, 1'b1);
        step();
        check("skid_reached", 64'(bus.ready_o), 64'd0);
        offer(1'b1, 32'h55, 1'b1, 1'b1);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_valid_o",   64'(bus.valid_o),      64'd0);
        check("flush_mem_write", 64'(bus.mem_writeM_o), 64'd0);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_emit", 64'(bus.valid_o), 64'd0);
        end
`else
        // Combinational ready: stall drops ready_o in the same cycle
        offer(1'b1, 32'h66, 1'b1, 1'b0);
        step();
        check("nsk_A_out", 64'(bus.alu_resultM_o), 64'h66);
        offer(1'b1, 32'h77, 1'b1, 1'b0);
        bus.ready_i = 1'b0;
        #1;
        check("nsk_ready_same_cycle", 64'(bus.ready_o), 64'd0);
        step();
        check("nsk_A_held", 64'(bus.alu_resultM_o), 64'h66);
        bus.ready_i = 1'b1;
        #1;
        check("nsk_ready_back", 64'(bus.ready_o), 64'd1);
        step();
        check("nsk_B_loaded", 64'(bus.alu_resultM_o), 64'h77);
        check("nsk_B_valid",  64'(bus.valid_o),       64'd1);
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("nsk_empty", 64'(bus.valid_o), 64'd0);

        // Flush while FULL with accept and deliver offered
        bus.ready_i = 1'b0;
        offer(1'b1, 32'hAA, 1'b0, 1'b1);
        step();
        check("nsk_store_held", 64'(bus.mem_writeM_o), 64'd1);
        offer(1'b1, 32'hBB, 1'b0, 1'b1);
        bus.ready_i = 1'b1;
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        check("nsk_flush_valid", 64'(bus.valid_o),      64'd0);
        check("nsk_flush_mw",    64'(bus.mem_writeM_o), 64'd0);
        step();
        check("nsk_flush_no_emit", 64'(bus.valid_o), 64'd0);
`endif

        // Reset while holding beats discards them
        bus.ready_i = 1'b0;
        offer(1'b1, 32'h88, 1'b1, 1'b1);
        step();
        offer(1'b1, 32'h99, 1'b1, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        check("midrst_valid_o", 64'(bus.valid_o),       64'd0);
        check("midrst_ready_o", 64'(bus.ready_o),       64'd1);
        check("midrst_alu",     64'(bus.alu_resultM_o), 64'd0);
        check("midrst_mw",      64'(bus.mem_writeM_o),  64'd0);
        bus.ready_i = 1'b1;
        step();
        step();
        check("midrst_no_emit", 64'(bus.valid_o), 64'd0);

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 200; i++) begin
            offer(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            bus.ready_i = ($urandom_range(0, 3) != 0);
            bus.flush_i = ($urandom_range(0, 15) == 0);
            step();
        end

        offer(1'b0, 32'h0, 1'b0, 1'b0);
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (4) step();
        check("final_drained", 64'(bus.valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ex_mem_stage
`default_nettype wire
